// File: rtl/jt89_gen.sv
// SN76489-family PSG: three square tones plus an LFSR noise channel, mixed to signed PCM.
// Defining JT89_STEREO_EN adds the Game Gear pan register (written with gg_wr).
module jt89_gen #(
  parameter int                 DIV       = 16,
  parameter int                 AMP_W     = 10,
  parameter int                 NOISE_W   = 16,
  parameter logic [NOISE_W-1:0] NOISE_TAP = NOISE_W'('h0009),
  parameter int                 WR_WAIT   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    wr_n,
`ifdef JT89_STEREO_EN
  input  logic                    gg_wr,
`endif
  input  logic [7:0]              din,
  output logic                    ready,
  output logic signed [AMP_W+2:0] left,
  output logic signed [AMP_W+2:0] right
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BUSY_W = $clog2(WR_WAIT + 1);
  localparam logic [NOISE_W-1:0] SEED = {1'b1, {(NOISE_W-1){1'b0}}};

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              wr_prev;
  logic [BUSY_W-1:0] busy;
  logic              accept;
  logic              gg_sel;
  logic              psg_wr;
  logic              noise_wr;
  logic [2:0]        wreg;
  logic [2:0]        regn;
  logic [2:0]        ctrl3;
  logic [9:0]        tone [3];
  logic [3:0]        vol  [4];
  logic [9:0]        tcnt [3];
  logic [2:0]        tout;
  logic [5:0]        ncnt;
  logic [5:0]        nreload;
  logic              ntog;
  logic              t2_rise;
  logic              n_rise;
  logic              shift;
  logic              fb;
  logic [NOISE_W-1:0] lfsr;
  logic [3:0]        chan_out;
  logic [7:0]        pan_eff;
  logic [AMP_W-1:0]  att_tab [16];
  logic signed [AMP_W:0]   ch [4];
  logic signed [AMP_W+2:0] sum_l;
  logic signed [AMP_W+2:0] sum_r;

  assign tick = cen && (div_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (cen) div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;
  end

  // Only a falling edge of wr_n while idle counts; busy counts cen pulses.
  assign accept = !wr_n && wr_prev && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev <= 1'b1;
      ready   <= 1'b1;
      busy    <= '0;
    end else begin
      wr_prev <= wr_n;
      if (accept) begin
        ready <= 1'b0;
        busy  <= BUSY_W'(WR_WAIT);
      end else if (!ready && cen) begin
        if (busy <= BUSY_W'(1)) begin
          ready <= 1'b1;
          busy  <= '0;
        end else begin
          busy <= busy - 1'b1;
        end
      end
    end
  end

`ifdef JT89_STEREO_EN
  logic [7:0] pan;
  assign gg_sel = gg_wr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pan <= 8'hFF;
    else if (accept && gg_wr) pan <= din;
  end
  assign pan_eff = pan;
`else
  assign gg_sel  = 1'b0;
  assign pan_eff = 8'hFF;
`endif

  assign psg_wr   = accept && !gg_sel;
  assign wreg     = din[7] ? din[6:4] : regn;
  assign noise_wr = psg_wr && (wreg == 3'b110);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regn  <= '0;
      ctrl3 <= 3'b100;
      for (int k = 0; k < 3; k++) tone[k] <= '0;
      for (int k = 0; k < 4; k++) vol[k]  <= 4'hF;
    end else if (psg_wr) begin
      if (din[7]) regn <= din[6:4];
      if (wreg[0]) vol[wreg[2:1]] <= din[3:0];
      else if (wreg == 3'b110) ctrl3 <= din[2:0];
      else if (din[7]) tone[wreg[2:1]][3:0] <= din[3:0];
      else tone[wreg[2:1]][9:4] <= din[5:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout <= 3'b111;
      for (int k = 0; k < 3; k++) tcnt[k] <= '0;
    end else if (tick) begin
      for (int k = 0; k < 3; k++) begin
        if (tone[k] <= 10'd1) begin
          tout[k] <= 1'b1;
          tcnt[k] <= '0;
        end else if (tcnt[k] == '0) begin
          tcnt[k] <= tone[k] - 10'd1;
          tout[k] <= ~tout[k];
        end else begin
          tcnt[k] <= tcnt[k] - 10'd1;
        end
      end
    end
  end

  // Rising edge of tone2 in this tick, including a DC-forced 0->1 step.
  assign t2_rise = tick && !tout[2] && ((tone[2] <= 10'd1) || (tcnt[2] == '0));

  always_comb begin
    nreload = 6'd63;
    case (ctrl3[1:0])
      2'b00:   nreload = 6'd15;
      2'b01:   nreload = 6'd31;
      default: nreload = 6'd63;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncnt <= '0;
      ntog <= 1'b0;
    end else if (tick) begin
      if (ncnt == '0) begin
        ncnt <= nreload;
        ntog <= ~ntog;
      end else begin
        ncnt <= ncnt - 6'd1;
      end
    end
  end

  assign n_rise = tick && (ncnt == '0) && !ntog;
  assign shift  = (ctrl3[1:0] == 2'b11) ? t2_rise : n_rise;
  assign fb     = ctrl3[2] ? ^(lfsr & NOISE_TAP) : lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else if (noise_wr) lfsr <= SEED;
    else if (shift) lfsr <= (lfsr == '0) ? SEED : {fb, lfsr[NOISE_W-1:1]};
  end

  // 2 dB per step: amplitude ratio 10^(-0.1) applied idx times.
  function automatic logic [AMP_W-1:0] att_amp(input int idx);
    real a;
    a = real'((1 << AMP_W) - 1);
    if (idx >= 15) return '0;
    for (int i = 0; i < idx; i++) a = a * 0.7943282347242815;
    return AMP_W'($rtoi(a + 0.5));
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_att
    assign att_tab[g] = att_amp(g);
  end

  assign chan_out = {lfsr[0], tout};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) ch[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        ch[k] <= chan_out[k] ? $signed({1'b0, att_tab[vol[k]]})
                             : -$signed({1'b0, att_tab[vol[k]]});
    end
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int k = 0; k < 4; k++) begin
      if (pan_eff[k])     sum_r = sum_r + (AMP_W+3)'(ch[k]);
      if (pan_eff[k + 4]) sum_l = sum_l + (AMP_W+3)'(ch[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left  <= '0;
      right <= '0;
    end else begin
      left  <= sum_l;
      right <= sum_r;
    end
  end

endmodule

// File: tb/tb_jt89_gen.sv
// Randomised bench for jt89_gen: tick-scheduled reference model feeds a scoreboard queue.
module tb_jt89_gen;
  localparam int AMP_W   = 10;
  localparam int DIV     = 16;
  localparam int NOISE_W = 16;
  localparam int WR_WAIT = 32;
  localparam int TAP     = 'h0009;
  localparam int SEED    = 1 << (NOISE_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic wr_n = 1'b1;
  logic gg_wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic ready;
  logic signed [AMP_W+2:0] left;
  logic signed [AMP_W+2:0] right;

  jt89_gen #(.DIV(DIV), .AMP_W(AMP_W), .NOISE_W(NOISE_W),
             .NOISE_TAP(16'h0009), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wr_n(wr_n),
`ifdef JT89_STEREO_EN
    .gg_wr(gg_wr),
`endif
    .din(din), .ready(ready), .left(left), .right(right));

  always #5 clk = ~clk;

  typedef struct { int l; int r; int rdy; bit to; } exp_t;
  exp_t q[$];
  bit done = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int amp_tab[16];
  int m_tone[3], m_next[3], m_out[3], m_vol[4], m_ch[4];
  int m_ctrl, m_regn, m_lfsr, m_nnext, m_ntog, m_tickno, m_cencnt;
  int m_busy, m_rdy, m_wrprev, m_pan, m_l, m_r;

  task automatic push_exp(input bit to);
    exp_t e;
    e.l = m_l; e.r = m_r; e.rdy = m_rdy; e.to = to;
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_tone[k] = 0; m_next[k] = 0; m_out[k] = 1; end
    for (int k = 0; k < 4; k++) begin m_vol[k] = 15; m_ch[k] = 0; end
    m_ctrl = 4; m_regn = 0; m_lfsr = SEED; m_nnext = 0; m_ntog = 0;
    m_tickno = 0; m_cencnt = 0; m_busy = 0; m_rdy = 1; m_wrprev = 1;
    m_pan = 255; m_l = 0; m_r = 0;
  endtask

  // Channels are scheduled by absolute tick number rather than countdown registers.
  task automatic model_clk(input logic c, input logic w, input logic [7:0] d, input logic g);
    int nl, nr, amp, r, fb, t, per, di;
    int nch[4];
    bit acc, tk, shift, t2r, nrise;
    di = int'(d);
    nl = 0; nr = 0;
    for (int k = 0; k < 4; k++) begin
      if (m_pan[k]) nr += m_ch[k];
      if (m_pan[k + 4]) nl += m_ch[k];
      amp = amp_tab[m_vol[k]];
      nch[k] = (((k == 3) ? (m_lfsr & 1) : m_out[k]) != 0) ? amp : -amp;
    end
    m_l = nl; m_r = nr;
    for (int k = 0; k < 4; k++) m_ch[k] = nch[k];
    acc = (w == 1'b0) && (m_wrprev != 0) && (m_rdy != 0);
    tk = c && ((m_cencnt % DIV) == 0);
    shift = 0;
    if (tk) begin
      t = m_tickno;
      t2r = 0;
      for (int k = 0; k < 3; k++) begin
        if (m_tone[k] <= 1) begin
          if (k == 2 && m_out[2] == 0) t2r = 1;
          m_out[k] = 1; m_next[k] = t + 1;
        end else if (t >= m_next[k]) begin
          if (k == 2 && m_out[2] == 0) t2r = 1;
          m_out[k] ^= 1; m_next[k] = t + m_tone[k];
        end
      end
      nrise = 0;
      if (t >= m_nnext) begin
        per = ((m_ctrl & 3) == 0) ? 16 : ((m_ctrl & 3) == 1) ? 32 : 64;
        nrise = (m_ntog == 0);
        m_ntog ^= 1;
        m_nnext = t + per;
      end
      shift = ((m_ctrl & 3) == 3) ? t2r : nrise;
      m_tickno++;
    end
    if (c) m_cencnt++;
    if (shift) begin
      if (m_lfsr == 0) m_lfsr = SEED;
      else begin
        fb = ((m_ctrl & 4) != 0) ? ($countones(m_lfsr & TAP) & 1) : (m_lfsr & 1);
        m_lfsr = (m_lfsr >> 1) | (fb << (NOISE_W - 1));
      end
    end
    if (acc) begin
      if (g) m_pan = di;
      else begin
        r = ((di & 128) != 0) ? ((di >> 4) & 7) : m_regn;
        if ((di & 128) != 0) m_regn = r;
        if ((r % 2) == 1) m_vol[r / 2] = di & 15;
        else if (r == 6) begin m_ctrl = di & 7; m_lfsr = SEED; end
        else if ((di & 128) != 0) m_tone[r / 2] = (m_tone[r / 2] & 'h3F0) | (di & 15);
        else m_tone[r / 2] = (m_tone[r / 2] & 'h00F) | ((di & 63) << 4);
      end
      m_rdy = 0; m_busy = WR_WAIT;
    end else if (m_rdy == 0 && c) begin
      m_busy--;
      if (m_busy == 0) m_rdy = 1;
    end
    m_wrprev = int'(w);
    push_exp(0);
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic g);
    logic c;
    c = ($urandom_range(0, 7) != 0);
    cen = c; wr_n = w; din = d; gg_wr = g;
    model_clk(c, w, d, g);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 8'h00, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; cen = 1'b0; wr_n = 1'b1; din = 8'h00; gg_wr = 1'b0;
    repeat (n) begin
      model_reset();
      push_exp(0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (m_rdy == 0 && n < 3000) begin step(1'b1, 8'h00, 1'b0); n++; end
    if (m_rdy == 0) push_exp(1);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic g, input int hold);
    wait_ready();
    step(1'b0, d, g);
    repeat (hold) step(1'b0, d, g);
    step(1'b1, d, g);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.to) chk("ready_wait_timeout", 0, 1);
        else begin
          chk("ready", int'(ready), e.rdy);
          chk("left", int'($signed(left)), e.l);
          chk("right", int'($signed(right)), e.r);
        end
      end
    end
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1);
  end

  initial begin : driver
    int c0, n;
    logic [7:0] rd;
    logic rg;
    for (int i = 0; i < 15; i++)
      amp_tab[i] = $rtoi(real'((1 << AMP_W) - 1) * $pow(10.0, -i / 10.0) + 0.5);
    amp_tab[15] = 0;
    model_reset();
    @(negedge clk);
    do_reset(4);
    idle(200);

`ifdef JT89_STEREO_EN
    wr_byte(8'h90, 1'b0, 0);
    wr_byte(8'h80, 1'b0, 0);
    wr_byte(8'h00, 1'b0, 0);
    wr_byte(8'h01, 1'b1, 0);
    idle(100);
    wr_byte(8'hFF, 1'b1, 0);
    idle(20);
`endif

    // tone0 = 14, vol0 = 0; last byte held low long past the busy window
    wr_byte(8'h8E, 1'b0, 0);
    wr_byte(8'h00, 1'b0, 0);
    wr_byte(8'h90, 1'b0, 80);
    idle(1500);

    // second falling edge 5 cen pulses into the busy window must be dropped
    wait_ready();
    step(1'b0, 8'hB0, 1'b0);
    c0 = m_cencnt; n = 0;
    while (m_cencnt - c0 < 5 && n < 100) begin step(1'b1, 8'hB0, 1'b0); n++; end
    repeat (3) step(1'b0, 8'hBF, 1'b0);
    step(1'b1, 8'hBF, 1'b0);
    idle(300);

    // white noise at rate 00, restarted mid-run
    wr_byte(8'hF0, 1'b0, 0);
    wr_byte(8'hE4, 1'b0, 0);
    idle(12000);
    wr_byte(8'hE0, 1'b0, 0);
    idle(2000);

    // noise clocked from tone2 = 100
    wr_byte(8'hC4, 1'b0, 0);
    wr_byte(8'h06, 1'b0, 0);
    wr_byte(8'hD0, 1'b0, 0);
    wr_byte(8'hE3, 1'b0, 0);
    idle(12000);
    wr_byte(8'hE7, 1'b0, 0);
    idle(8000);

    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
`ifdef JT89_STEREO_EN
      rg = ($urandom_range(0, 9) == 0);
`else
      rg = 1'b0;
`endif
      wr_byte(rd, rg, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, 8'h00, 1'b0);
      end
      idle($urandom_range(0, 150));
    end

    // reset while busy: ready must come straight back
    wait_ready();
    step(1'b0, 8'h9F, 1'b0);
    step(1'b0, 8'h9F, 1'b0);
    do_reset(3);
    idle(100);
    done = 1;
  end

endmodule
